mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
// - Iterative multiply/divide unit owning the HI/LO register pair; sits beside the
//   ALU in EX and takes the same operands (data1 = rs, data2 = rt) from the ID/EX stage.
// - Executes MULT/MULTU/DIV/DIVU (and optionally MADD/MADDU) over multiple cycles,
//   plus single-cycle MTHI/MTLO; presents HI/LO to the MFHI/MFLO path.
// - busy output is consumed by hazard logic to stall the pipeline on any HI/LO access.
// PARAMETERS
// - WIDTH  32  operand width; iteration count = WIDTH; product/quotient pair = 2*WIDTH
// PORTS
// - clk      in   1      rising-edge clock
// - rst      in   1      reset, asynchronous, active-high
// - start    in   1      request; sampled only when busy=0
// - op       in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MADDU, 110 MTHI, 111 MTLO
// - data1    in   WIDTH  rs operand (multiplicand / dividend / MTHI/MTLO source)
// - data2    in   WIDTH  rt operand (multiplier / divisor)
// - flush    in   1      abort an in-flight op (branch/exception squash)
// - busy     out  1      op in progress; HI/LO not yet valid
// - done     out  1      one-cycle pulse: HI/LO updated this cycle
// - hi, lo   out  WIDTH  architectural HI/LO registers
// BEHAVIOUR
// - Reset: state=IDLE, busy=0, done=0, hi=0, lo=0, all internal regs 0; applies immediately, mid-op included.
// - FSM: IDLE -> MUL|DIV (WIDTH cycles, one bit per cycle) -> FIX (1 cycle) -> IDLE.
// - Accept (edge 0): start=1, busy=0, flush=0; operands/op latched; busy=1 from edge 0.
// - Iterations on edges 1..WIDTH; FIX on edge WIDTH+1 writes hi/lo, done=1, busy=0.
// - Latency start->done = WIDTH+1 cycles (33); a new start is accepted in the done cycle.
// - MUL: signed ops use operand magnitudes, unsigned shift-add, negate 2*WIDTH product in
//   FIX if signs differ; {hi,lo} = product. MULTU: no sign handling.
// - DIV: restoring, magnitudes; lo = quotient truncated toward zero, hi = remainder with
//   sign of dividend. DIVU unsigned. Signed 0x80000000 / -1: lo=0x80000000, hi=0.
// - Divide by zero (data2=0): full latency, lo=all ones, hi=data1 (unsigned and signed).
// - MTHI/MTLO: no busy; hi (or lo) <= data1 on accept edge, done=1 the following cycle.
// - start while busy=1: ignored, no queuing; hi/lo never change except in FIX or MTHI/MTLO.
// - flush while busy: returns to IDLE next edge, busy=0, done stays 0, hi/lo unchanged.
// - flush and start same cycle with busy=0: flush wins, nothing accepted.
// - flush in the FIX cycle: FIX still commits (the result is already architectural).
// - All arithmetic modulo 2^(2*WIDTH); no overflow flags.
// CONFIGURATION
// - MULT_DIV_MADD_EN defined: MADD/MADDU run the MUL path; FIX does
//   {hi,lo} <= {hi,lo} + product (signed / unsigned product respectively), mod 2^64.
// - Undefined: op 100/101 accepted as no-op: no busy, done=1 next cycle, hi/lo unchanged.
// TESTING
// - Reset mid-DIV at iteration 10 -> busy=0, hi=lo=0 immediately; no done pulse.
// - MULT 0xFFFFFFFD(-3) x 7 -> done at cycle 33; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
// - MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
// - DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/0 -> lo=0xFFFFFFFF, hi=100.
// - Start MULT, flush at cycle 5, then start MTLO 0x1234 -> hi/lo unchanged by MULT; lo=0x1234, done next cycle.
// - MADD with hi=0, lo=0xFFFFFFFF, 1 x 1 -> macro defined: hi=1, lo=0; undefined: unchanged.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// Handshake/operand bundle between the EX stage and the HI/LO multiply/divide unit.
interface mult_div_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, data1, data2, flush, input busy, done, hi, lo);
  modport slave  (input start, op, data1, data2, flush, output busy, done, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, plus single-cycle MTHI/MTLO.
// Define MULT_DIV_MADD_EN to enable MADD/MADDU accumulation; otherwise those ops are no-ops.
//
// state  | meaning
// S_IDLE | waiting for start; MTHI/MTLO/no-op complete here
// S_MUL  | shift-add, one multiplier bit per cycle
// S_DIV  | restoring divide, one quotient bit per cycle
// S_FIX  | sign fix-up and HI/LO commit, done pulse
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  mult_div_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_madd, r_div;
  logic               r_neg, r_rneg, r_dz;
  logic               r_busy, r_done;
  logic [WIDTH-1:0]   r_a, r_d1, r_hi, r_lo;
  logic [2*WIDTH-1:0] r_p;

  logic               w_accept, w_s1, w_s2, w_dge;
  logic [WIDTH-1:0]   w_mag1, w_mag2, w_dsub, w_dnew, w_quo, w_rem;
  logic [WIDTH:0]     w_msum, w_drem;
  logic [2*WIDTH-1:0] w_prod_s, w_hilo_sum;

  assign w_accept = bus.start & ~r_busy & ~bus.flush;
  assign w_s1     = ~bus.op[0] & bus.data1[WIDTH-1];
  assign w_s2     = ~bus.op[0] & bus.data2[WIDTH-1];
  assign w_mag1   = w_s1 ? -bus.data1 : bus.data1;
  assign w_mag2   = w_s2 ? -bus.data2 : bus.data2;

  // r_p holds {partial product, remaining multiplier} or {remainder, dividend/quotient}
  assign w_msum   = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_a} : '0);
  assign w_drem   = r_p[2*WIDTH-1:WIDTH-1];
  assign w_dge    = w_drem >= {1'b0, r_a};
  assign w_dsub   = w_drem[WIDTH-1:0] - r_a;
  assign w_dnew   = w_dge ? w_dsub : w_drem[WIDTH-1:0];

  assign w_quo      = r_p[WIDTH-1:0];
  assign w_rem      = r_p[2*WIDTH-1:WIDTH];
  assign w_prod_s   = r_neg ? -r_p : r_p;
  assign w_hilo_sum = {r_hi, r_lo} + w_prod_s;

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_madd  <= 1'b0;
      r_div   <= 1'b0;
      r_neg   <= 1'b0;
      r_rneg  <= 1'b0;
      r_dz    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_a     <= '0;
      r_d1    <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_p     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt  <= CW'(WIDTH - 1);
            r_madd <= bus.op[2];
            r_div  <= bus.op[1];
            r_neg  <= w_s1 ^ w_s2;
            r_rneg <= w_s1;
            r_dz   <= (bus.data2 == '0);
            r_d1   <= bus.data1;
            case (bus.op)
`ifdef MULT_DIV_MADD_EN
              3'b000, 3'b001, 3'b100, 3'b101: begin
`else
              3'b000, 3'b001: begin
`endif
                r_state <= S_MUL;
                r_busy  <= 1'b1;
                r_a     <= w_mag1;
                r_p     <= {{WIDTH{1'b0}}, w_mag2};
              end
              3'b010, 3'b011: begin
                r_state <= S_DIV;
                r_busy  <= 1'b1;
                r_a     <= w_mag2;
                r_p     <= {{WIDTH{1'b0}}, w_mag1};
              end
              3'b110: begin
                r_hi   <= bus.data1;
                r_done <= 1'b1;
              end
              3'b111: begin
                r_lo   <= bus.data1;
                r_done <= 1'b1;
              end
              default: r_done <= 1'b1;
            endcase
          end
        end
        S_MUL, S_DIV: begin
          if (bus.flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            if (r_state == S_MUL) r_p <= {w_msum, r_p[WIDTH-1:1]};
            else                  r_p <= {w_dnew, r_p[WIDTH-2:0], w_dge};
            if (r_cnt == '0) r_state <= S_FIX;
            else             r_cnt   <= r_cnt - CW'(1);
          end
        end
        S_FIX: begin
          // commits regardless of flush: the result is already architectural
          if (r_div) begin
            if (r_dz) begin
              r_lo <= '1;
              r_hi <= r_d1;
            end else begin
              r_lo <= r_neg  ? -w_quo : w_quo;
              r_hi <= r_rneg ? -w_rem : w_rem;
            end
          end else if (r_madd) begin
            {r_hi, r_lo} <= w_hilo_sum;
          end else begin
            {r_hi, r_lo} <= w_prod_s;
          end
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit; expected values are hand-computed constants.
module tb_mult_div_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_div_unit_if #(.WIDTH(W)) bus();

  mult_div_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  // called at a negedge; returns at the negedge after the accept edge
  task automatic issue(input logic [2:0] op, input logic [W-1:0] d1, input logic [W-1:0] d2);
    bus.start = 1'b1;
    bus.op    = op;
    bus.data1 = d1;
    bus.data2 = d2;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic [W-1:0] d1,
                     input logic [W-1:0] d2, input logic [W-1:0] ehi, input logic [W-1:0] elo);
    int n;
    issue(op, d1, d2);
    check({tag, " busy"}, bus.busy, 1);
    wait_done(n);
    check({tag, " latency"}, n, 33);
    check({tag, " hi"}, bus.hi, ehi);
    check({tag, " lo"}, bus.lo, elo);
  endtask

  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) cnt++;
    end
  endtask

  initial begin
    int n;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = 3'b000;
    bus.data1 = '0;
    bus.data2 = '0;
    repeat (2) @(negedge clk);
    check("rst busy", bus.busy, 0);
    check("rst done", bus.done, 0);
    check("rst hi", bus.hi, 0);
    check("rst lo", bus.lo, 0);
    rst = 1'b0;
    @(negedge clk);

    run("mult -3x7", 3'b000, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    @(negedge clk);
    check("done one-cycle", bus.done, 0);
    run("multu max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run("div -7/2", 3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("divu 100/0", 3'b011, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
    run("div min/-1", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run("div 7/-2", 3'b010, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    // started in the done cycle of the previous op
    run("b2b multu", 3'b001, 32'd6, 32'd7, 32'd0, 32'd42);

    issue(3'b001, 32'd3, 32'd5);
    repeat (3) @(negedge clk);
    issue(3'b111, 32'h0000_DEAD, 32'd0);
    check("busy ignore lo", bus.lo, 32'd42);
    check("busy ignore hi", bus.hi, 32'd0);
    wait_done(n);
    check("ignored start result lo", bus.lo, 32'd15);

    issue(3'b000, 32'd2, 32'd3);
    repeat (4) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush busy", bus.busy, 0);
    check("flush done", bus.done, 0);
    check("flush lo", bus.lo, 32'd15);
    issue(3'b111, 32'h0000_1234, 32'd0);
    check("mtlo lo", bus.lo, 32'h0000_1234);
    check("mtlo done", bus.done, 1);
    check("mtlo busy", bus.busy, 0);
    check("mtlo hi", bus.hi, 32'd0);
    count_done(40, n);
    check("flushed no done", n, 0);

    bus.flush = 1'b1;
    issue(3'b110, 32'h5555_5555, 32'd0);
    bus.flush = 1'b0;
    check("flush+start done", bus.done, 0);
    check("flush+start hi", bus.hi, 32'd0);

    issue(3'b111, 32'hFFFF_FFFF, 32'd0);
`ifdef MULT_DIV_MADD_EN
    run("madd", 3'b100, 32'd1, 32'd1, 32'd1, 32'd0);
`else
    issue(3'b100, 32'd1, 32'd1);
    check("madd nop done", bus.done, 1);
    check("madd nop busy", bus.busy, 0);
    check("madd nop hi", bus.hi, 32'd0);
    check("madd nop lo", bus.lo, 32'hFFFF_FFFF);
`endif

    issue(3'b001, 32'd6, 32'd7);
    repeat (32) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush in fix done", bus.done, 1);
    check("flush in fix lo", bus.lo, 32'd42);
    check("flush in fix hi", bus.hi, 32'd0);

    issue(3'b110, 32'h0000_AAAA, 32'd0);
    issue(3'b010, 32'd100, 32'd3);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid-div rst busy", bus.busy, 0);
    check("mid-div rst hi", bus.hi, 0);
    check("mid-div rst lo", bus.lo, 0);
    @(negedge clk);
    rst = 1'b0;
    count_done(40, n);
    check("mid-div rst no done", n, 0);
    check("mid-div rst idle", bus.busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
